// File: rtl/lgdst_spi_pkg.sv
// Shared definitions for the LGDST CPLD SPI masters.
//   - FSM state encodings (legacy-compatible localparam constants)
//   - RW_READ: value of the frame's leading rw bit that selects a register read
//   - frame_w(): serial frame length, one rw bit plus address plus data
package lgdst_spi_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    localparam logic RW_READ = 1'b1;

    function automatic int unsigned frame_w(input int unsigned addr_w, input int unsigned data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_clk_tick.sv
// Phase timer for the SPI master FSM.
// Down-counter reloading CLK_DIV-1; tick_o is high for the one clk cycle that ends a
// CLK_DIV-cycle phase. clr_i restarts the phase so every FSM state starts aligned.
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset
//   clr_i   restart the phase (asserted on FSM state change)
//   tick_o  last cycle of the current phase
module spi_clk_tick
    import lgdst_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned CntW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] Reload = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] cnt_d, cnt_q;

    assign tick_o = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q - 1'b1;
        if (clr_i || tick_o) begin
            cnt_d = Reload;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= Reload;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/adrf_spi3w_master.sv
// 3-wire SPI master for direct ADRF6612 register access from CPLD logic.
// One command at a time is taken on a valid/ready interface and serialised MSB first
// as {rw, addr, data} on the shared SDIO line; reads turn the line around after the
// last address bit and return the captured data on a one-cycle response strobe.
//   clk_i, rst_ni           system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     command handshake (ready only while idle)
//   cmd_rw/addr/wdata       command fields (wdata ignored for reads)
//   rsp_valid/rsp_rdata     end-of-transaction pulse and read data (0 after writes)
//   ad_spi_cs/sclk/sdio     device pins; cs active low, sclk idles low, sdio tristate
module adrf_spi3w_master
    import lgdst_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned DATA_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rw,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              ad_spi_cs,
    output logic              ad_spi_sclk,
    inout  wire               ad_spi_sdio
);

    localparam int unsigned FRAME = frame_w(ADDR_W, DATA_W);
    localparam int unsigned BitW  = $clog2(FRAME);
    localparam logic [BitW-1:0] LastBit = BitW'(FRAME - 1);
    localparam logic [BitW-1:0] TurnBit = BitW'(ADDR_W);

    logic [2:0]        state_d, state_q;
    logic              cs_d, cs_q;
    logic              sclk_d, sclk_q;
    logic              oe_d, oe_q;
    logic              rw_d, rw_q;
    logic [FRAME-1:0]  tx_d, tx_q;
    logic [DATA_W-1:0] rx_d, rx_q;
    logic [BitW-1:0]   bit_d, bit_q;
    logic              rsp_valid_d, rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_d, rsp_rdata_q;
    logic              cmd_ready_d, cmd_ready_q;
    logic              tick;
    logic              phase_clr;

    // Every state entry restarts the phase timer.
    assign phase_clr = (state_d != state_q);

    spi_clk_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .clr_i (phase_clr),
        .tick_o(tick)
    );

    always_comb begin
        state_d     = state_q;
        cs_d        = cs_q;
        sclk_d      = sclk_q;
        oe_d        = oe_q;
        rw_d        = rw_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        bit_d       = bit_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    tx_d    = {cmd_rw, cmd_addr, cmd_wdata};
                    rw_d    = cmd_rw;
                    rx_d    = '0;
                    bit_d   = '0;
                    cs_d    = 1'b0;
                    oe_d    = 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    sclk_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (sclk_q) begin
                        // End of high phase: capture read data, then fall.
                        if (rw_q == RW_READ && bit_q > TurnBit) begin
                            rx_d = {rx_q[DATA_W-2:0], ad_spi_sdio};
                        end
                        sclk_d = 1'b0;
                        if (bit_q == LastBit) begin
                            state_d = ST_HOLD;
                        end else begin
                            tx_d  = {tx_q[FRAME-2:0], 1'b0};
                            bit_d = bit_q + 1'b1;
                            // Release the line once the last address bit is done.
                            if (rw_q == RW_READ && bit_q == TurnBit) begin
                                oe_d = 1'b0;
                            end
                        end
                    end else begin
                        sclk_d = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    cs_d        = 1'b1;
                    oe_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = (rw_q == RW_READ) ? rx_q : '0;
                    state_d     = ST_GAP;
                end
            end
            ST_GAP: begin
                if (tick) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cs_d    = 1'b1;
                sclk_d  = 1'b0;
                oe_d    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cs_q        <= 1'b1;
            sclk_q      <= 1'b0;
            oe_q        <= 1'b0;
            rw_q        <= 1'b0;
            tx_q        <= '0;
            rx_q        <= '0;
            bit_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cs_q        <= cs_d;
            sclk_q      <= sclk_d;
            oe_q        <= oe_d;
            rw_q        <= rw_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            bit_q       <= bit_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign ad_spi_cs   = cs_q;
    assign ad_spi_sclk = sclk_q;
    assign ad_spi_sdio = oe_q ? tx_q[FRAME-1] : 1'bz;

endmodule
